id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the 5-stage RV32I core. It sits directly downstream of the decode stage and the immediate sign-extender. It captures the decoded controls, register-file read data, the sign-extended immediate, the funct fields and the register addresses, and presents them to the EX stage (ALU, ALU control, forwarding unit). It supports hold on stall, bubble insertion on flush, and a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg_pkg.sv | 47 ++++
 rtl/id_ex_pipe_reg_pipe_field_reg.sv | 40 ++++
 rtl/id_ex_pipe_reg.sv | 140 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : id_ex_pipe_reg_pkg                                          |
// | Purpose  : Shared types and constants for the ID/EX pipeline register: |
// |            ALUOp class encodings, the packed control bundle, the NOP   |
// |            bubble constant and the two-state stall selector.           |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package id_ex_pipe_reg_pkg;

  // ALU operation classes decoded by the ALU control block in EX
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branches: compare/subtract
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // R-type: decode funct7/funct3
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;  // I-type ALU: decode funct3

  // Decoded control bundle carried into EX; valid travels with the controls
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  // A bubble is all-zero: no write-back, no memory access, ALUOP_ADD
  localparam ctrl_t CTRL_NOP = '0;

  // Only two stall states exist; HOLDING is selected directly by stall_i
  typedef enum logic [0:0] {
    ST_LOADING = 1'b0,
    ST_HOLDING = 1'b1
  } stall_state_e;

  // An invalid instruction must never carry side-effecting controls into EX
  function automatic ctrl_t gate_ctrl(input ctrl_t c);
    ctrl_t r;
    r = c.valid ? c : CTRL_NOP;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_reg_pipe_field_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pipe_field_reg                                              |
// | Purpose  : Parameterised-width pipeline register with async active-low |
// |            reset, synchronous clear (wins over hold) and hold.         |
// | Ports    : clk_i   - clock                                             |
// |            rst_i   - asynchronous active-low reset                     |
// |            i_hold  - keep current contents                             |
// |            i_clear - load zero                                         |
// |            i_d     - next value                                        |
// |            o_q     - registered value                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : id_ex_pipe_reg                                              |
// | Purpose  : ID/EX pipeline register of the 5-stage RV32I core. Captures |
// |            decoded controls, register read data, immediate, funct and  |
// |            register indices; supports stall (hold), flush (bubble) and |
// |            a saturating bubble counter.                                |
// | Ports    : clk_i, rst_i (async active-low), stall_i, flush_i, valid_i  |
// |            pc_i, rs1_data_i, rs2_data_i, imm_i, funct_i,               |
// |            rs1_addr_i, rs2_addr_i, rd_addr_i, control inputs           |
// |            *_o registered copies, bubble_cnt_o                         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int               c_DATA_GRP_W = 4 * DATA_W;
  localparam int               c_ADDR_GRP_W = 10 + 3 * 5;
  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

  stall_state_e            w_state;
  logic                    w_hold;
  logic                    w_clear;
  ctrl_t                   w_ctrl_raw;
  ctrl_t                   w_ctrl_d;
  ctrl_t                   w_ctrl_q;
  logic [c_DATA_GRP_W-1:0] w_data_q;
  logic [c_ADDR_GRP_W-1:0] w_addr_q;
  logic                    w_bubble;
  logic [CNT_W-1:0]        r_bubble_cnt;

  // Flush outranks stall: clear has priority inside pipe_field_reg
  assign w_state = stall_i ? ST_HOLDING : ST_LOADING;
  assign w_hold  = (w_state == ST_HOLDING);
  assign w_clear = flush_i;

  assign w_ctrl_raw = '{valid:      valid_i,
                        reg_write:  RegWrite_i,
                        mem_to_reg: MemtoReg_i,
                        mem_read:   MemRead_i,
                        mem_write:  MemWrite_i,
                        alu_src:    ALUSrc_i,
                        alu_op:     ALUOp_i};
  // Gating at the D side keeps controls 0 whenever valid_o is 0
  assign w_ctrl_d = gate_ctrl(w_ctrl_raw);

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_hold  (w_hold),
    .i_clear (w_clear),
    .i_d     (w_ctrl_d),
    .o_q     (w_ctrl_q)
  );

  // Data fields load even for invalid instructions; only flush clears them
  pipe_field_reg #(.W(c_DATA_GRP_W)) u_data_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_hold  (w_hold),
    .i_clear (w_clear),
    .i_d     ({pc_i, rs1_data_i, rs2_data_i, imm_i}),
    .o_q     (w_data_q)
  );

  pipe_field_reg #(.W(c_ADDR_GRP_W)) u_addr_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_hold  (w_hold),
    .i_clear (w_clear),
    .i_d     ({funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i}),
    .o_q     (w_addr_q)
  );

  // A bubble enters EX on flush, or on a non-stalled edge with no valid op
  assign w_bubble = flush_i | (~stall_i & ~valid_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign valid_o    = w_ctrl_q.valid;
  assign RegWrite_o = w_ctrl_q.reg_write;
  assign MemtoReg_o = w_ctrl_q.mem_to_reg;
  assign MemRead_o  = w_ctrl_q.mem_read;
  assign MemWrite_o = w_ctrl_q.mem_write;
  assign ALUSrc_o   = w_ctrl_q.alu_src;
  assign ALUOp_o    = w_ctrl_q.alu_op;

  assign {pc_o, rs1_data_o, rs2_data_o, imm_o}           = w_data_q;
  assign {funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o}    = w_addr_q;

  assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_id_ex_pipe_reg                                           |
// | Purpose  : Directed self-checking bench for id_ex_pipe_reg (CNT_W = 4) |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              stall_i, flush_i, valid_i;
  logic [DATA_W-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]        funct_i;
  logic [4:0]        rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic              valid_o;
  logic [DATA_W-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]        funct_o;
  logic [4:0]        rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]        ALUOp_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct_i(funct_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .funct_o(funct_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    valid_i    = v;
    pc_i       = pc;
    imm_i      = imm;
    rd_addr_i  = rd;
    RegWrite_i = rw;
    MemRead_i  = mr;
    MemWrite_i = mw;
  endtask

  task automatic test_reset;
    stall_i = 0; flush_i = 0;
    drive(1'b1, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    rs1_data_i = 32'h1234; rs2_data_i = 32'h5678; funct_i = 10'h155;
    rs1_addr_i = 5'd1; rs2_addr_i = 5'd2;
    MemtoReg_i = 1; ALUSrc_i = 1; ALUOp_i = 2'b10;
    tick;
    checks++;
    if (pc_o !== 32'h40 || RegWrite_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: pc_o=%h RegWrite_o=%b, required pc_o=40 RegWrite_o=1", pc_o, RegWrite_o);
    end
    // Assert reset between edges; outputs must clear with no edge
    #2 rst_i = 0;
    #1;
    checks++;
    if ({valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o,
         rd_addr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o} !== '0) begin
      errors++;
      $display("FAIL reset_async_clear: pc_o=%h valid_o=%b RegWrite_o=%b, required all zero", pc_o, valid_o, RegWrite_o);
    end
    checks++;
    if (bubble_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_counter: bubble_cnt_o=%0d, required 0", bubble_cnt_o);
    end
    exp_cnt = 0;
    @(negedge clk_i);
    rst_i = 1;
  endtask

  task automatic test_normal;
    drive(1'b1, 32'h10, 32'hFFFF_FFF6, 5'd5, 1'b1, 1'b0, 1'b0);
    rs1_data_i = 32'hAAAA_0001; rs2_data_i = 32'hBBBB_0002;
    tick;
    checks++;
    if (pc_o !== 32'h10 || imm_o !== 32'hFFFF_FFF6 || rd_addr_o !== 5'd5) begin
      errors++;
      $display("FAIL normal_data: pc_o=%h imm_o=%h rd_addr_o=%0d, required 10 fffffff6 5", pc_o, imm_o, rd_addr_o);
    end
    checks++;
    if (RegWrite_o !== 1'b1 || valid_o !== 1'b1 || rs1_data_o !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL normal_ctrl: RegWrite_o=%b valid_o=%b rs1_data_o=%h, required 1 1 aaaa0001", RegWrite_o, valid_o, rs1_data_o);
    end
    checks++;
    if (bubble_cnt_o !== exp_cnt[CNT_W-1:0]) begin
      errors++;
      $display("FAIL normal_counter: bubble_cnt_o=%0d, required %0d", bubble_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_stall;
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      // Changing inputs, including an invalid op, must all be ignored
      drive(i[0], 32'h100 + i, 32'h7, 5'd9, 1'b0, 1'b1, 1'b1);
      tick;
      checks++;
      if (pc_o !== 32'h10 || imm_o !== 32'hFFFF_FFF6 || valid_o !== 1'b1 || RegWrite_o !== 1'b1
          || MemRead_o !== 1'b0 || bubble_cnt_o !== exp_cnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc_o=%h valid_o=%b RegWrite_o=%b cnt=%0d, required 10 1 1 cnt=%0d",
                 i, pc_o, valid_o, RegWrite_o, bubble_cnt_o, exp_cnt);
      end
    end
    stall_i = 0;
    // SRAI-style immediate: shamt 5 in the low bits, funct7 bit in imm[10]
    drive(1'b1, 32'h24, 32'h0000_0405, 5'd6, 1'b1, 1'b0, 1'b0);
    tick;
    checks++;
    if (pc_o !== 32'h24 || imm_o !== 32'h0000_0405 || imm_o[4:0] !== 5'd5 || rd_addr_o !== 5'd6) begin
      errors++;
      $display("FAIL stall_release: pc_o=%h imm_o=%h rd_addr_o=%0d, required 24 00000405 6", pc_o, imm_o, rd_addr_o);
    end
  endtask

  task automatic test_flush;
    stall_i = 1; flush_i = 1;
    drive(1'b1, 32'h30, 32'h33, 5'd8, 1'b1, 1'b1, 1'b1);
    tick;
    exp_cnt++;
    checks++;
    if ({valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o,
         rd_addr_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o} !== '0) begin
      errors++;
      $display("FAIL flush_bubble: pc_o=%h valid_o=%b rd_addr_o=%0d MemRead_o=%b, required all zero", pc_o, valid_o, rd_addr_o, MemRead_o);
    end
    checks++;
    if (bubble_cnt_o !== exp_cnt[CNT_W-1:0]) begin
      errors++;
      $display("FAIL flush_counter: bubble_cnt_o=%0d, required %0d", bubble_cnt_o, exp_cnt);
    end
    stall_i = 0; flush_i = 0;
  endtask

  task automatic test_invalid;
    drive(1'b0, 32'h88, 32'h99, 5'd7, 1'b1, 1'b0, 1'b1);
    rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'hCAFE_F00D;
    tick;
    exp_cnt++;
    checks++;
    if (valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemWrite_o !== 1'b0) begin
      errors++;
      $display("FAIL invalid_gating: valid_o=%b RegWrite_o=%b MemWrite_o=%b, required 0 0 0", valid_o, RegWrite_o, MemWrite_o);
    end
    checks++;
    if (pc_o !== 32'h88 || imm_o !== 32'h99 || rd_addr_o !== 5'd7 || rs1_data_o !== 32'hDEAD_BEEF
        || rs2_data_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL invalid_data: pc_o=%h imm_o=%h rs1=%h rs2=%h, required 88 99 deadbeef cafef00d", pc_o, imm_o, rs1_data_o, rs2_data_o);
    end
    checks++;
    if (bubble_cnt_o !== exp_cnt[CNT_W-1:0]) begin
      errors++;
      $display("FAIL invalid_counter: bubble_cnt_o=%0d, required %0d", bubble_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_saturation;
    flush_i = 1;
    drive(1'b1, 32'h50, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick;
      if (exp_cnt < 15) exp_cnt++;
      checks++;
      if (bubble_cnt_o !== exp_cnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL saturate_step_%0d: bubble_cnt_o=%0d, required %0d", i, bubble_cnt_o, exp_cnt);
      end
    end
    checks++;
    if (bubble_cnt_o !== 4'd15) begin
      errors++;
      $display("FAIL saturate_final: bubble_cnt_o=%0d, required 15", bubble_cnt_o);
    end
    // An invalid-instruction bubble after saturation must not wrap
    flush_i = 0; valid_i = 0;
    tick;
    checks++;
    if (bubble_cnt_o !== 4'd15 || valid_o !== 1'b0 || pc_o !== 32'h50) begin
      errors++;
      $display("FAIL saturate_hold: bubble_cnt_o=%0d valid_o=%b pc_o=%h, required 15 0 50", bubble_cnt_o, valid_o, pc_o);
    end
  endtask

  initial begin
    rst_i = 0; stall_i = 0; flush_i = 0;
    drive(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    rs1_data_i = '0; rs2_data_i = '0; funct_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0;
    MemtoReg_i = 0; ALUSrc_i = 0; ALUOp_i = '0;
    #12;
    checks++;
    if (valid_o !== 1'b0 || pc_o !== '0 || bubble_cnt_o !== '0) begin
      errors++;
      $display("FAIL power_on_reset: valid_o=%b pc_o=%h cnt=%0d, required 0 0 0", valid_o, pc_o, bubble_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1;
    test_reset;
    test_normal;
    test_stall;
    test_flush;
    test_invalid;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
